// File: rtl/pixel_layer_arbiter.sv
// pixel_layer_arbiter
// Chooses, for each pixel, the highest-priority opaque sprite layer (or the
// background) and drives its palette index. The palette RGB is registered as
// the VGA colour. Sprites can blink with the frame counter. Overlaps between
// opaque layers are accumulated and reported once per frame.
//
// Flow control: there is no valid/ready handshake. pix_en is a one-Clk
// qualifier. Both pipeline stages load together when pix_en is high and hold
// when it is low. vsync_pulse is an unqualified one-Clk strobe.
module pixel_layer_arbiter #(
  parameter int          NUM_LAYERS = 4,
  parameter logic [3:0]  TRANSP_IDX = 4'h9,
  parameter int          LW         = $clog2(NUM_LAYERS)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    pix_en,
  input  logic                    de,
  input  logic                    vsync_pulse,
  input  logic [NUM_LAYERS-1:0]   layer_hit,
  input  logic [4*NUM_LAYERS-1:0] layer_idx,
  input  logic [3:0]              bg_idx,
  input  logic [NUM_LAYERS-1:0]   flash_layer,
  output logic [3:0]              pal_index,
  input  logic [3:0]              pal_red,
  input  logic [3:0]              pal_green,
  input  logic [3:0]              pal_blue,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    de_out,
  output logic [LW:0]             winner,
  output logic [NUM_LAYERS-1:0]   coll_flags,
  output logic                    coll_valid
);

  // Frame counter; bit 3 drives the blink phase (8 frames on, 8 frames off).
  logic [4:0]            frame_cnt;

  // Stage-1 side-band that travels alongside pal_index.
  logic                  s1_de;
  logic [LW:0]           s1_win;

  // Collision bits seen so far in the current frame.
  logic [NUM_LAYERS-1:0] coll_acc;

  // Combinational per-pixel results.
  logic [NUM_LAYERS-1:0] opaque;
  logic [NUM_LAYERS-1:0] coll_hit;
  logic [NUM_LAYERS-1:0] pix_coll;
  logic [3:0]            win_idx;
  logic [LW:0]           win_code;

  // Opacity of each layer: hit, not the transparent index, and not blinked out.
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = layer_hit[i]
                  && (layer_idx[4*i +: 4] != TRANSP_IDX)
                  && !(flash_layer[i] && frame_cnt[3]);
    end
  end

  // Priority select. Scan from the lowest priority upward so layer 0 lands last.
  always_comb begin
    win_idx  = bg_idx;
    win_code = {1'b1, {LW{1'b0}}};
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_idx  = layer_idx[4*i +: 4];
        win_code = {1'b0, LW'(i)};
      end
    end
  end

  // Collision term: layer i is opaque and at least one other layer is opaque.
  always_comb begin
    coll_hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      coll_hit[i] = opaque[i] && ((opaque & ~(NUM_LAYERS'(1) << i)) != '0);
    end
    pix_coll = (pix_en && de) ? coll_hit : '0;
  end

  // Frame counter advances on each frame-start strobe and wraps naturally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt <= '0;
    end else if (vsync_pulse) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  // Stage 1: palette index plus the side-band that travels with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pal_index <= '0;
      s1_de     <= 1'b0;
      s1_win    <= '0;
    end else if (pix_en) begin
      pal_index <= de ? win_idx : 4'h0;
      s1_de     <= de;
      s1_win    <= win_code;
    end
  end

  // Stage 2: register the palette response. Blanked pixels are forced to
  // black so an undriven palette can never reach the display.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      de_out <= 1'b0;
      winner <= '0;
    end else if (pix_en) begin
      red    <= s1_de ? pal_red   : 4'h0;
      green  <= s1_de ? pal_green : 4'h0;
      blue   <= s1_de ? pal_blue  : 4'h0;
      de_out <= s1_de;
      winner <= s1_win;
    end
  end

  // Collision accumulation. A pixel that coincides with vsync belongs to the
  // frame that is being reported, not to the new one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      coll_acc   <= '0;
      coll_flags <= '0;
      coll_valid <= 1'b0;
    end else if (vsync_pulse) begin
      coll_flags <= coll_acc | pix_coll;
      coll_acc   <= '0;
      coll_valid <= 1'b1;
    end else begin
      coll_acc   <= coll_acc | pix_coll;
      coll_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Bench for pixel_layer_arbiter (4 layers). A palette ROM answers pal_index
// combinationally. Each strobe pushes the expected stage-2 output to exp_q,
// and that entry is popped one strobe later.
module tb_pixel_layer_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        pix_en;
  logic        de;
  logic        vsync_pulse;
  logic [3:0]  layer_hit;
  logic [15:0] layer_idx;
  logic [3:0]  bg_idx;
  logic [3:0]  flash_layer;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red;
  logic [3:0]  pal_green;
  logic [3:0]  pal_blue;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        de_out;
  logic [2:0]  winner;
  logic [3:0]  coll_flags;
  logic        coll_valid;

  logic [11:0] pal_rom [16];

  // Expected stage-2 outputs packed as {de_out, winner, red, green, blue}.
  logic [15:0] exp_q[$];
  logic [15:0] out_last;
  logic [3:0]  pal_last;
  logic [3:0]  tb_acc;
  logic [4:0]  tb_frame;
  int          vectors;
  int          miscompares;

  pixel_layer_arbiter #(.NUM_LAYERS(4), .TRANSP_IDX(4'h9)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .pix_en     (pix_en),
    .de         (de),
    .vsync_pulse(vsync_pulse),
    .layer_hit  (layer_hit),
    .layer_idx  (layer_idx),
    .bg_idx     (bg_idx),
    .flash_layer(flash_layer),
    .pal_index  (pal_index),
    .pal_red    (pal_red),
    .pal_green  (pal_green),
    .pal_blue   (pal_blue),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .de_out     (de_out),
    .winner     (winner),
    .coll_flags (coll_flags),
    .coll_valid (coll_valid)
  );

  // Combinational palette.
  assign {pal_red, pal_green, pal_blue} = pal_rom[pal_index];

  // Clock and reset block.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert reset between edges, confirm every output clears before the next
  // edge, then release reset. The model restarts from the reset state.
  task automatic do_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst_pal_index", 32'(pal_index), 32'h0);
    check("rst_rgb", 32'({red, green, blue}), 32'h0);
    check("rst_de_out", 32'(de_out), 32'h0);
    check("rst_winner", 32'(winner), 32'h0);
    check("rst_coll_flags", 32'(coll_flags), 32'h0);
    check("rst_coll_valid", 32'(coll_valid), 32'h0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(16'h0);  // stage 1 after reset: de 0, winner 0
    out_last = 16'h0;
    pal_last = 4'h0;
    tb_acc   = 4'h0;
    tb_frame = 5'd0;
  endtask

  // Driver for one Clk. pe/vs select pix_en and vsync_pulse. The expected
  // behaviour is modelled from the pixel inputs and the bench's own frame count.
  task automatic drive(input bit pe, input bit vs, input bit d, input logic [3:0] hit,
                       input logic [15:0] idx, input logic [3:0] flash, input logic [3:0] bg);
    logic [3:0] op;
    logic [3:0] ch;
    logic [3:0] exp_idx;
    logic [3:0] exp_pal;
    logic [2:0] wcode;
    logic [3:0] contrib;
    logic [3:0] exp_flags;
    logic [15:0] ent;
    bit found;
    op = 4'h0;
    for (int i = 0; i < 4; i++)
      op[i] = hit[i] && (idx[4*i +: 4] != 4'h9) && !(flash[i] && tb_frame[3]);
    found = 1'b0;
    exp_idx = bg;
    wcode = 3'b100;
    for (int i = 0; i < 4; i++) begin
      if (op[i] && !found) begin
        found = 1'b1;
        exp_idx = idx[4*i +: 4];
        wcode = 3'(i);
      end
    end
    ch = ($countones(op) >= 2) ? op : 4'h0;
    exp_pal = d ? exp_idx : 4'h0;
    contrib = (pe && d) ? ch : 4'h0;
    exp_flags = 4'h0;
    if (vs) begin
      exp_flags = tb_acc | contrib;
      tb_acc = 4'h0;
      tb_frame = tb_frame + 5'd1;
    end else begin
      tb_acc = tb_acc | contrib;
    end
    if (pe) exp_q.push_back({d, wcode, d ? pal_rom[exp_pal] : 12'h0});

    pix_en = pe; vsync_pulse = vs; de = d;
    layer_hit = hit; layer_idx = idx; flash_layer = flash; bg_idx = bg;
    @(posedge Clk);
    #1;
    pix_en = 1'b0;
    vsync_pulse = 1'b0;

    if (pe) begin
      pal_last = exp_pal;
      check("pal_index", 32'(pal_index), 32'(exp_pal));
      if (exp_q.size() >= 2) begin
        ent = exp_q.pop_front();
        out_last = ent;
        check("stage2_out", 32'({de_out, winner, red, green, blue}), 32'(ent));
      end
    end
    check("coll_valid", 32'(coll_valid), 32'(vs));
    if (vs) check("coll_flags", 32'(coll_flags), 32'(exp_flags));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      pal_rom[i] = {k, ~k, k ^ 4'h3};
    end
    pal_rom[2] = 12'hFEE;
    pal_rom[4] = 12'h522;
    vectors = 0;
    miscompares = 0;
    Reset_n = 1'b1;
    pix_en = 1'b0; vsync_pulse = 1'b0; de = 1'b0;
    layer_hit = '0; layer_idx = '0; bg_idx = 4'h4; flash_layer = '0;
    tb_acc = 4'h0; tb_frame = 5'd0; out_last = 16'h0; pal_last = 4'h0;
    @(posedge Clk);
    #1;
    do_reset();

    // Priority: layers 1 and 2 hit, layer 1 wins with index 2.
    drive(1, 0, 1, 4'b0110, 16'h0520, 4'h0, 4'h4);
    check("prio_pal", 32'(pal_index), 32'h2);
    // Transparency fallback to background index 4.
    drive(1, 0, 1, 4'b0001, 16'h0009, 4'h0, 4'h4);
    check("prio_rgb", 32'({red, green, blue}), 32'hFEE);
    check("prio_winner", 32'(winner), 32'h1);
    drive(1, 0, 1, 4'b0000, 16'h0000, 4'h0, 4'h7);
    check("transp_rgb", 32'({red, green, blue}), 32'h522);
    check("transp_winner", 32'(winner), 32'h4);

    // Blanking, then hold with pix_en low.
    drive(1, 0, 0, 4'b0001, 16'h0003, 4'h0, 4'h4);
    drive(1, 0, 0, 4'b0001, 16'h0003, 4'h0, 4'h4);
    check("blank_rgb", 32'({red, green, blue, de_out}), 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      #1;
      check("hold_pal", 32'(pal_index), 32'(pal_last));
      check("hold_out", 32'({de_out, winner, red, green, blue}), 32'(out_last));
    end

    // Blink: frame 8 hides layer 0, frame 16 shows it again.
    do_reset();
    for (int c = 0; c < 8; c++) drive(0, 1, 0, 4'h0, 16'h0, 4'h0, 4'h4);
    drive(1, 0, 1, 4'b0001, 16'h0003, 4'b0001, 4'h4);
    check("blink_off_pal", 32'(pal_index), 32'h4);
    for (int c = 0; c < 8; c++) drive(0, 1, 0, 4'h0, 16'h0, 4'h0, 4'h4);
    drive(1, 0, 1, 4'b0001, 16'h0003, 4'b0001, 4'h4);
    check("blink_on_pal", 32'(pal_index), 32'h3);

    // Collision between layers 0 and 3, then a clean frame.
    drive(1, 0, 1, 4'b1001, 16'h7003, 4'h0, 4'h4);
    drive(0, 1, 0, 4'h0, 16'h0, 4'h0, 4'h4);
    check("coll_1001", 32'(coll_flags), 32'h9);
    drive(1, 0, 1, 4'b0001, 16'h7003, 4'h0, 4'h4);
    drive(0, 1, 0, 4'h0, 16'h0, 4'h0, 4'h4);
    check("coll_none", 32'(coll_flags), 32'h0);
    drive(0, 0, 0, 4'h0, 16'h0, 4'h0, 4'h4);
    // Overlap on the same Clk as vsync, then back-to-back vsync.
    drive(1, 1, 1, 4'b1001, 16'h7003, 4'h0, 4'h4);
    check("coll_simul", 32'(coll_flags), 32'h9);
    drive(0, 1, 0, 4'h0, 16'h0, 4'h0, 4'h4);
    check("coll_b2b", 32'(coll_flags), 32'h0);

    // Mid-pipeline reset, then a frame with a fresh overlap.
    drive(1, 0, 1, 4'b0110, 16'h0520, 4'h0, 4'h4);
    do_reset();
    drive(1, 0, 1, 4'b0011, 16'h0052, 4'h0, 4'h4);
    drive(0, 1, 0, 4'h0, 16'h0, 4'h0, 4'h4);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ri;
      ri = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) ri[3:0] = 4'h9;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), ri,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
